// File: rtl/insn_fetch_buf.sv
// Instruction fetch front-end: owns the fetch PC, runs a single-outstanding
// bus read and buffers returned words in a 2-entry prefetch queue.
module insn_fetch_buf #(
  parameter int                 ADDR_W   = 30,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [DATA_W-1:0]  NOP_INSN = '0
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] NewPC,
  input  logic              BrTaken,
  input  logic [ADDR_W-1:0] BrAddr,
  output logic              BusReq,
  output logic [ADDR_W-1:0] BusAddr,
  input  logic              BusAck,
  input  logic [DATA_W-1:0] BusRdData,
  output logic [DATA_W-1:0] Insn,
  output logic [ADDR_W-1:0] InsnPC,
  output logic              InsnValid,
  output logic              FetchStall
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] data_q [2];
  logic [ADDR_W-1:0] pc_q [2];
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              redir;
  logic              pop;
  logic              enq;
  logic [ADDR_W-1:0] tgt;

  assign redir      = Flush | BrTaken;
  assign tgt        = Flush ? NewPC : BrAddr;
  assign InsnValid  = (cnt_q != 2'd0);
  assign Insn       = InsnValid ? data_q[rd_q] : NOP_INSN;
  assign InsnPC     = InsnValid ? pc_q[rd_q] : '0;
  assign FetchStall = ~InsnValid & ~redir;
  assign BusAddr    = bus_addr_q;
  assign pop        = InsnValid & ~Stall & ~redir;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    bus_addr_d = bus_addr_q;
    BusReq     = 1'b0;
    enq        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redir && cnt_q < 2'd2) begin
          bus_addr_d = fetch_pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        BusReq = 1'b1;
        if (BusAck) begin
          state_d = IDLE;
          if (!redir) begin
            enq        = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          end
        end else if (redir) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // the bus cycle cannot be cancelled; wait it out and drop the data
        BusReq = 1'b1;
        if (BusAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redir) fetch_pc_d = tgt;
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (redir) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (pop) rd_d = ~rd_q;
      if (enq) wr_d = ~wr_q;
      if (enq && !pop) cnt_d = cnt_q + 2'd1;
      else if (pop && !enq) cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      bus_addr_q <= RESET_PC;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 2'd0;
      data_q[0]  <= '0;
      data_q[1]  <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      bus_addr_q <= bus_addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      if (enq) begin
        data_q[wr_q] <= BusRdData;
        pc_q[wr_q]   <= bus_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_insn_fetch_buf.sv
// Bench for insn_fetch_buf: vector table, bus responder with programmable
// ack delay, scoreboard of expected queue heads.
module tb_insn_fetch_buf;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_ = 1'b1;
  logic          Stall = 1'b0;
  logic          Flush = 1'b0;
  logic          BrTaken = 1'b0;
  logic          BusAck = 1'b0;
  logic [AW-1:0] NewPC = '0;
  logic [AW-1:0] BrAddr = '0;
  logic [DW-1:0] BusRdData = '0;
  logic          BusReq, InsnValid, FetchStall;
  logic [AW-1:0] BusAddr, InsnPC;
  logic [DW-1:0] Insn;

  logic          rst2 = 1'b1;
  logic          stall2 = 1'b1;
  logic          b2_ack = 1'b1;
  logic          zero1 = 1'b0;
  logic [AW-1:0] zaddr = '0;
  logic          b2_req, v2, fs2;
  logic [AW-1:0] b2_addr, pc2;
  logic [DW-1:0] b2_data, insn2;

  assign b2_data = {2'b00, b2_addr} + 32'h100;

  insn_fetch_buf dut (
    .clk(clk), .reset_(reset_), .Stall(Stall),
    .Flush(Flush), .NewPC(NewPC),
    .BrTaken(BrTaken), .BrAddr(BrAddr),
    .BusReq(BusReq), .BusAddr(BusAddr),
    .BusAck(BusAck), .BusRdData(BusRdData),
    .Insn(Insn), .InsnPC(InsnPC),
    .InsnValid(InsnValid), .FetchStall(FetchStall)
  );

  insn_fetch_buf #(.RESET_PC(30'h3FFFFFFF)) dut2 (
    .clk(clk), .reset_(rst2), .Stall(stall2),
    .Flush(zero1), .NewPC(zaddr),
    .BrTaken(zero1), .BrAddr(zaddr),
    .BusReq(b2_req), .BusAddr(b2_addr),
    .BusAck(b2_ack), .BusRdData(b2_data),
    .Insn(insn2), .InsnPC(pc2),
    .InsnValid(v2), .FetchStall(fs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] pc;
  } ent_t;

  typedef struct {
    logic          stall;
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [DW-1:0] insn;
    logic [AW-1:0] pc;
  } vec_t;

  ent_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          tb_out = 1'b0;
  logic          tb_drop = 1'b0;
  logic [AW-1:0] exp_pc = '0;
  logic [AW-1:0] req_addr = '0;
  int            wait_cnt = 0;
  int            ack_delay = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // one clock: answer the bus, check heads, advance the model
  task automatic cycle();
    logic          redir;
    logic [AW-1:0] tgt;
    redir = Flush | BrTaken;
    tgt   = Flush ? NewPC : BrAddr;
    if (BusReq && !tb_out) begin
      chk("req_addr", 64'(BusAddr), 64'(exp_pc));
      req_addr = exp_pc;
      tb_out   = 1'b1;
      wait_cnt = 0;
    end else if (BusReq) begin
      chk("req_hold", 64'(BusAddr), 64'(req_addr));
    end else if (tb_out) begin
      chk("req_lost", 64'(BusReq), 64'd1);
    end
    BusAck    = BusReq && (wait_cnt >= ack_delay);
    BusRdData = {2'b00, BusAddr} + 32'h100;
    #1;
    chk("valid", 64'(InsnValid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("insn", 64'(Insn), 64'(sb[0].data));
      chk("insn_pc", 64'(InsnPC), 64'(sb[0].pc));
    end
    chk("fetch_stall", 64'(FetchStall), 64'(sb.size() == 0 && !redir));
    if (!redir && !Stall && sb.size() != 0) void'(sb.pop_front());
    if (BusAck) begin
      if (!redir && !tb_drop) begin
        sb.push_back('{data: {2'b00, req_addr} + 32'h100, pc: req_addr});
        exp_pc = req_addr + 30'd1;
      end
      tb_out  = 1'b0;
      tb_drop = 1'b0;
    end else if (tb_out) begin
      wait_cnt++;
      if (redir) tb_drop = 1'b1;
    end
    if (redir) begin
      sb.delete();
      exp_pc = tgt;
    end
    @(posedge clk);
    #1;
    BusAck = 1'b0;
  endtask

  task automatic wait_new_req();
    int n = 0;
    while (!(BusReq && !tb_out) && n < 20) begin
      cycle();
      n++;
    end
    if (n >= 20) chk("req_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!InsnValid && n < 20) begin
      cycle();
      n++;
    end
    if (n >= 20) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[7];
    tv[0] = '{0, 0, 30'h0, 0, 32'h0,   30'h0};
    tv[1] = '{0, 1, 30'h0, 0, 32'h0,   30'h0};
    tv[2] = '{0, 0, 30'h0, 1, 32'h100, 30'h0};
    tv[3] = '{0, 1, 30'h1, 0, 32'h0,   30'h0};
    tv[4] = '{0, 0, 30'h1, 1, 32'h101, 30'h1};
    tv[5] = '{0, 1, 30'h2, 0, 32'h0,   30'h0};
    tv[6] = '{0, 0, 30'h2, 1, 32'h102, 30'h2};

    repeat (2) @(posedge clk);
    #1 reset_ = 1'b0;
    #1;
    for (int i = 0; i < 7; i++) begin
      Stall = tv[i].stall;
      chk($sformatf("tv%0d_req", i), 64'(BusReq), 64'(tv[i].req));
      chk($sformatf("tv%0d_addr", i), 64'(BusAddr), 64'(tv[i].addr));
      chk($sformatf("tv%0d_valid", i), 64'(InsnValid), 64'(tv[i].valid));
      chk($sformatf("tv%0d_insn", i), 64'(Insn), 64'(tv[i].insn));
      chk($sformatf("tv%0d_pc", i), 64'(InsnPC), 64'(tv[i].pc));
      cycle();
    end

    Stall = 1'b1;
    repeat (10) cycle();
    chk("stall_busreq", 64'(BusReq), 64'd0);
    chk("stall_valid", 64'(InsnValid), 64'd1);
    chk("stall_head", 64'(Insn), 64'h103);
    chk("stall_count", 64'(sb.size()), 64'd2);
    Stall = 1'b0;
    cycle();
    chk("drain_head", 64'(Insn), 64'h104);
    repeat (8) cycle();

    ack_delay = 3;
    BrTaken = 1'b1;
    BrAddr  = 30'h5;
    cycle();
    BrTaken = 1'b0;
    wait_new_req();
    chk("br_req5", 64'(BusAddr), 64'h5);
    BrTaken = 1'b1;
    BrAddr  = 30'h40;
    cycle();
    BrTaken = 1'b0;
    chk("drop_req", 64'(BusReq), 64'd1);
    chk("drop_addr", 64'(BusAddr), 64'h5);
    cycle();
    chk("drop_req2", 64'(BusReq), 64'd1);
    chk("drop_addr2", 64'(BusAddr), 64'h5);
    wait_new_req();
    chk("br_target", 64'(BusAddr), 64'h40);
    wait_valid();
    chk("br_first_pc", 64'(InsnPC), 64'h40);
    chk("br_first_insn", 64'(Insn), 64'h140);

    ack_delay = 0;
    wait_new_req();
    Flush   = 1'b1;
    NewPC   = 30'h80;
    BrTaken = 1'b1;
    BrAddr  = 30'h40;
    #1;
    chk("redir_fstall", 64'(FetchStall), 64'd0);
    cycle();
    Flush   = 1'b0;
    BrTaken = 1'b0;
    chk("redir_empty", 64'(InsnValid), 64'd0);
    wait_new_req();
    chk("flush_prio", 64'(BusAddr), 64'h80);

    wait_new_req();
    Flush = 1'b1;
    NewPC = 30'h20;
    cycle();
    Flush = 1'b0;
    chk("ackflush_valid", 64'(InsnValid), 64'd0);
    wait_new_req();
    chk("ackflush_addr", 64'(BusAddr), 64'h20);
    wait_valid();
    chk("ackflush_pc", 64'(InsnPC), 64'h20);

    Flush = 1'b1;
    NewPC = 30'h3FFFFFFF;
    cycle();
    Flush = 1'b0;
    wait_new_req();
    chk("wrap_first", 64'(BusAddr), 64'h3FFFFFFF);
    cycle();
    wait_new_req();
    chk("wrap_second", 64'(BusAddr), 64'h0);
    repeat (4) cycle();

    reset_ = 1'b1;
    rst2   = 1'b0;
    #1;
    chk("r2_req", 64'(b2_req), 64'd0);
    chk("r2_addr", 64'(b2_addr), 64'h3FFFFFFF);
    chk("r2_valid", 64'(v2), 64'd0);
    chk("r2_insn", 64'(insn2), 64'd0);
    chk("r2_pc", 64'(pc2), 64'd0);
    chk("r2_fstall", 64'(fs2), 64'd1);
    @(posedge clk);
    #1;
    chk("r2_req1", 64'(b2_req), 64'd1);
    chk("r2_addr1", 64'(b2_addr), 64'h3FFFFFFF);
    chk("r2_idle_ack", 64'(v2), 64'd0);
    @(posedge clk);
    #1;
    chk("r2_valid2", 64'(v2), 64'd1);
    chk("r2_pc2", 64'(pc2), 64'h3FFFFFFF);
    chk("r2_insn2", 64'(insn2), 64'h400000FF);
    @(posedge clk);
    #1;
    chk("r2_req3", 64'(b2_req), 64'd1);
    chk("r2_addr3", 64'(b2_addr), 64'h0);
    chk("r2_valid3", 64'(v2), 64'd1);
    #1 rst2 = 1'b1;
    #1;
    chk("r2_async_req", 64'(b2_req), 64'd0);
    chk("r2_async_valid", 64'(v2), 64'd0);
    chk("r2_async_addr", 64'(b2_addr), 64'h3FFFFFFF);
    chk("r2_async_insn", 64'(insn2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
